// File: rtl/muldiv_sequencer.sv
// Issue sequencer for the HI/LO multiply/divide unit: handles accept/stall, divider busy tracking,
// MTHI/MTLO overrides and MFHI/MFLO reads. Optional divide-by-zero trap: MULDIV_DIVZERO_TRAP_EN.
module muldiv_sequencer #(
    parameter int unsigned DIV_LATENCY = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opValid,
    input  logic [2:0]  opCode,
    input  logic [31:0] rsVal,
    input  logic [31:0] rtVal,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdData,
    output logic        rdValid,
    output logic        divZero,
    output logic [31:0] multA,
    output logic [31:0] multB,
    output logic [31:0] divA,
    output logic [31:0] divB,
    output logic        enableMult,
    output logic        isSignedMult,
    output logic        enableDiv,
    output logic        isSignedDiv,
    input  logic [31:0] hi,
    input  logic [31:0] lo
);

    localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi_ovr;
    logic [31:0]      r_lo_ovr;
    logic             r_hi_ovr_vld;
    logic             r_lo_ovr_vld;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;

    logic w_busy;
    logic w_accept;
    logic w_is_mult;
    logic w_is_div;
    logic w_div_trap;
    logic w_div_issue;
    logic w_rd_accept;

    assign w_busy      = (r_cnt != '0);
    assign w_accept    = opValid && !flush && !w_busy;
    assign w_is_mult   = (opCode == OP_MULT) || (opCode == OP_MULTU);
    assign w_is_div    = (opCode == OP_DIV)  || (opCode == OP_DIVU);
    assign w_div_issue = w_accept && w_is_div && !w_div_trap;
    assign w_rd_accept = w_accept && ((opCode == OP_MFHI) || (opCode == OP_MFLO));

    // Operands pass straight through; the unit only samples them when enabled.
    assign multA        = rsVal;
    assign multB        = rtVal;
    assign divA         = rsVal;
    assign divB         = rtVal;
    assign stall        = opValid && !flush && w_busy;
    assign enableMult   = w_accept && w_is_mult;
    assign isSignedMult = w_accept && (opCode == OP_MULT);
    assign enableDiv    = w_div_issue;
    assign isSignedDiv  = w_div_issue && (opCode == OP_DIV);
    assign rdData       = r_rd_data;
    assign rdValid      = r_rd_valid;

`ifdef MULDIV_DIVZERO_TRAP_EN
    logic r_div_zero;

    // A trapped divide is swallowed: no issue, no busy window, overrides kept.
    assign w_div_trap = w_accept && w_is_div && (rtVal == 32'd0);
    assign divZero    = r_div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_div_trap;
        end
    end
`else
    assign w_div_trap = 1'b0;
    assign divZero    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_hi_ovr     <= '0;
            r_lo_ovr     <= '0;
            r_hi_ovr_vld <= 1'b0;
            r_lo_ovr_vld <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            if (w_div_issue) begin
                r_cnt <= CNT_W'(DIV_LATENCY);
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // A new unit result supersedes any pending MTHI/MTLO value.
            if (enableMult || w_div_issue) begin
                r_hi_ovr_vld <= 1'b0;
                r_lo_ovr_vld <= 1'b0;
            end else if (w_accept && (opCode == OP_MTHI)) begin
                r_hi_ovr     <= rsVal;
                r_hi_ovr_vld <= 1'b1;
            end else if (w_accept && (opCode == OP_MTLO)) begin
                r_lo_ovr     <= rsVal;
                r_lo_ovr_vld <= 1'b1;
            end

            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                if (opCode == OP_MFHI) begin
                    r_rd_data <= r_hi_ovr_vld ? r_hi_ovr : hi;
                end else begin
                    r_rd_data <= r_lo_ovr_vld ? r_lo_ovr : lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural multiply/divide unit and a read scoreboard.
// Works with or without MULDIV_DIVZERO_TRAP_EN defined.
module tb_muldiv_sequencer;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        opValid;
    logic [2:0]  opCode;
    logic [31:0] rsVal, rtVal;
    logic        flush;
    logic        stall;
    logic [31:0] rdData;
    logic        rdValid;
    logic        divZero;
    logic [31:0] multA, multB, divA, divB;
    logic        enableMult, isSignedMult, enableDiv, isSignedDiv;
    logic [31:0] hi = 32'd0;
    logic [31:0] lo = 32'd0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] exp_q[$];
    logic        exp_rdv = 1'b0;
    logic        exp_dz  = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DIV_LATENCY(11)) dut (
        .clk(clk), .rst_n(rst_n), .opValid(opValid), .opCode(opCode),
        .rsVal(rsVal), .rtVal(rtVal), .flush(flush), .stall(stall),
        .rdData(rdData), .rdValid(rdValid), .divZero(divZero),
        .multA(multA), .multB(multB), .divA(divA), .divB(divB),
        .enableMult(enableMult), .isSignedMult(isSignedMult),
        .enableDiv(enableDiv), .isSignedDiv(isSignedDiv),
        .hi(hi), .lo(lo)
    );

    // Behavioural mult/div unit: results land on the edge the op is issued.
    always @(posedge clk) begin
        if (enableMult) begin
            if (isSignedMult) {hi, lo} <= 64'($signed(multA)) * 64'($signed(multB));
            else              {hi, lo} <= {32'd0, multA} * {32'd0, multB};
        end else if (enableDiv && divB != 32'd0) begin
            if (isSignedDiv) begin
                lo <= 32'($signed(divA) / $signed(divB));
                hi <= 32'($signed(divA) % $signed(divB));
            end else begin
                lo <= divA / divB;
                hi <= divA % divB;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check registered outputs of the previous edge, drive, check combinational outputs.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic fl, input logic exp_stall, input logic [31:0] exp_rd);
        logic acc, is_div, trap_now;
        @(negedge clk);
        check("rdValid", 32'(rdValid), 32'(exp_rdv));
        check("divZero", 32'(divZero), 32'(exp_dz));
        if (exp_rdv) begin
            if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
            else                   check("rdData", rdData, exp_q.pop_front());
        end
        opValid = v; opCode = op; rsVal = rs; rtVal = rt; flush = fl;
        #1;
        acc      = v && !fl && !exp_stall;
        is_div   = (op == DIV) || (op == DIVU);
        trap_now = TRAP && acc && is_div && (rt == 32'd0);
        check("stall",        32'(stall),        32'(v && !fl && exp_stall));
        check("enableMult",   32'(enableMult),   32'(acc && (op == MULT || op == MULTU)));
        check("isSignedMult", 32'(isSignedMult), 32'(acc && op == MULT));
        check("enableDiv",    32'(enableDiv),    32'(acc && is_div && !trap_now));
        check("isSignedDiv",  32'(isSignedDiv),  32'(acc && op == DIV && !trap_now));
        check("multA", multA, rs);
        check("divB",  divB,  rt);
        exp_rdv = acc && (op == MFHI || op == MFLO);
        exp_dz  = trap_now;
        if (exp_rdv) exp_q.push_back(exp_rd);
    endtask

    task automatic idle();
        step(1'b0, MULT, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; opValid = 1'b0; opCode = 3'd0; rsVal = '0; rtVal = '0; flush = 1'b0;
        #12;
        check("reset_rdData",  rdData, 32'd0);
        check("reset_rdValid", 32'(rdValid), 32'd0);
        check("reset_divZero", 32'(divZero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed multiply, then back-to-back reads with no stall
        step(1, MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 32'd0);
        step(1, MFHI, 32'd0, 32'd0, 0, 0, 32'hFFFF_FFFF);
        step(1, MFLO, 32'd0, 32'd0, 0, 0, 32'hFFFF_FFF1);
        idle();

        // Unsigned divide: read stalls for the full busy window
        step(1, DIVU, 32'd100, 32'd7, 0, 0, 32'd0);
        for (int i = 0; i < 11; i++) step(1, MFLO, 32'd0, 32'd0, 0, 1, 32'd0);
        step(1, MFLO, 32'd0, 32'd0, 0, 0, 32'd14);
        step(1, MFHI, 32'd0, 32'd0, 0, 0, 32'd2);
        idle();

        // Override then fresh multiply result
        step(1, MTHI, 32'h0000_1234, 32'd0, 0, 0, 32'd0);
        step(1, MFHI, 32'd0, 32'd0, 0, 0, 32'h0000_1234);
        step(1, MULTU, 32'd2, 32'd3, 0, 0, 32'd0);
        step(1, MFHI, 32'd0, 32'd0, 0, 0, 32'd0);
        step(1, MFLO, 32'd0, 32'd0, 0, 0, 32'd6);
        idle();

        // Flushed divide issues nothing and leaves the unit idle
        step(1, DIV, 32'd9, 32'd3, 1, 0, 32'd0);
        step(1, MFHI, 32'd0, 32'd0, 0, 0, 32'd0);
        idle();

        // Divide by zero: trapped (no busy) or issued normally (11 busy cycles)
        step(1, DIV, 32'd5, 32'd0, 0, 0, 32'd0);
        for (int i = 0; i < 11; i++) step(1, MFLO, 32'd0, 32'd0, 0, !TRAP, 32'd6);
        step(1, MFLO, 32'd0, 32'd0, 0, 0, 32'd6);
        idle();

        // Reset mid-divide aborts the busy window
        step(1, DIVU, 32'd100, 32'd7, 0, 0, 32'd0);
        for (int i = 0; i < 5; i++) step(1, MFLO, 32'd0, 32'd0, 0, 1, 32'd0);
        @(negedge clk);
        check("pre_reset_rdValid", 32'(rdValid), 32'd0);
        rst_n = 1'b0; opValid = 1'b1; opCode = MFLO; flush = 1'b0;
        #1;
        check("in_reset_stall",   32'(stall),   32'd0);
        check("in_reset_rdValid", 32'(rdValid), 32'd0);
        exp_rdv = 1'b0; exp_dz = 1'b0; exp_q.delete();
        @(negedge clk);
        opValid = 1'b0;
        rst_n = 1'b1;
        step(1, MTLO, 32'h0000_0055, 32'd0, 0, 0, 32'd0);
        step(1, MFLO, 32'd0, 32'd0, 0, 0, 32'h0000_0055);
        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 11, meaning cycles the divider is busy after enableDiv is accepted.
REQ-002 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opValid  input  1  an HI/LO-class op is presented this cycle.
REQ-005 SHALL have port opCode  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-006 SHALL have port rsVal, rtVal  input  32 each  operands; MTHI/MTLO use rsVal.
REQ-007 SHALL have port flush  input  1  cancel the op presented this cycle.
REQ-008 SHALL have port stall  output  1  op presented but not accepted this cycle.
REQ-009 SHALL have port rdData  output  32  MFHI/MFLO result.
REQ-010 SHALL have port rdValid  output  1  rdData valid, one-cycle pulse.
REQ-011 SHALL have port divZero  output  1  divide-by-zero pulse (see Configuration).
REQ-012 SHALL have ports multA, multB, divA, divB  output  32 each  operands to the multiplier/divider unit.
REQ-013 SHALL have ports enableMult, isSignedMult, enableDiv, isSignedDiv  output  1 each  unit controls.
REQ-014 SHALL have ports hi, lo  input  32 each  unit result registers.

Function
REQ-015 SHALL accept an op when opValid && !flush && !stall; flush wins over opValid in the same cycle, nothing issued.
REQ-016 SHALL drive multA=divA=rsVal and multB=divB=rtVal combinationally at all times.
REQ-017 SHALL assert enableMult combinationally in the accept cycle of MULT/MULTU, isSignedMult=1 only for MULT.
REQ-018 SHALL assert enableDiv combinationally in the accept cycle of DIV/DIVU, isSignedDiv=1 only for DIV.
REQ-019 SHALL keep a busy counter: loaded with DIV_LATENCY on accepted DIV/DIVU, decremented by 1 each cycle while nonzero; busy = counter != 0.
REQ-020 SHALL drive stall = opValid && !flush && busy for every opcode (no op overlaps a divide).
REQ-021 SHALL accept a MULT/MULTU with no following stall; MFHI/MFLO one cycle later reads the new result.
REQ-022 SHALL hold hiOvr/loOvr 32-bit registers with valid flags: accepted MTHI loads hiOvr=rsVal and sets its flag; MTLO likewise for lo.
REQ-023 SHALL clear both override flags on any accepted MULT/MULTU/DIV/DIVU.
REQ-024 SHALL, on accepted MFHI at cycle T, register rdData = (hi flag ? hiOvr : hi) and pulse rdValid at T+1; MFLO likewise with lo.
REQ-025 SHALL hold rdData unchanged and rdValid=0 when no read is accepted.
REQ-026 SHALL treat MTHI followed by MFHI in the next cycle as returning the new override value.

Reset
REQ-027 SHALL, on rst_n low, immediately clear counter, override flags and registers, rdData, rdValid and divZero to 0.
REQ-028 SHALL treat reset during a divide as abort: busy=0 after reset, no stall, no rdValid until a new read is accepted.

Configuration
REQ-029 SHALL use macro MULDIV_DIVZERO_TRAP_EN.
REQ-030 SHALL, with MULDIV_DIVZERO_TRAP_EN defined, on accepted DIV/DIVU with rtVal==0: not assert enableDiv, not load the counter, keep override flags, and pulse divZero (registered) at T+1.
REQ-031 SHALL, without the macro, issue DIV/DIVU with rtVal==0 normally and tie divZero to 0.

Verification
REQ-032 SHALL cover: MULT rs=0xFFFFFFFD rt=5, MFHI then MFLO next cycles -> rdData 0xFFFFFFFF then 0xFFFFFFF1, no stall.
REQ-033 SHALL cover: DIVU 100/7 at T, MFLO presented T+1 -> stall T+1..T+11, accepted T+12, rdData=14 at T+13; then MFHI -> 2.
REQ-034 SHALL cover: MTHI 0x00001234 then MFHI -> 0x00001234; then MULTU 2*3, MFHI -> 0x00000000.
REQ-035 SHALL cover: macro defined, DIV 5/0 -> enableDiv 0, divZero 1 for one cycle, stall never asserted; macro undefined -> enableDiv 1, busy 11 cycles.
REQ-036 SHALL cover: rst_n low while counter=6, released -> stall 0, rdValid 0, MTLO 0x55 then MFLO -> 0x00000055.
REQ-037 SHALL cover: opValid+flush with DIV -> enableDiv 0, counter stays 0.
